// File: rtl/serial_adder16.sv
// Bit-serial adder: one full_adder cell plus a carry flip-flop produce one
// result bit per clock, LSB first. Start/busy/done handshake; the result
// registers hold their value until the next completion.

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    // Holds the WIDTH-1 result bits collected so far; the final bit comes
    // straight from the adder on the completion edge.
    logic [WIDTH-2:0] r_part;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_fa_s;
    logic             w_fa_c;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_part_full;

    full_adder u_fa (
        .i_a (r_opa[0]),
        .i_b (r_opb[0]),
        .i_c (r_carry),
        .o_s (w_fa_s),
        .o_c (w_fa_c)
    );

    // A new request is taken whenever no operation is in flight.
    assign w_accept    = start && (r_state != S_RUN);
    assign w_last      = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
    assign w_part_full = {w_fa_s, r_part};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: RUN lasts exactly WIDTH edges, DONE exactly one.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, one bit per RUN edge, result update on the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_part  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_opa   <= a;
            r_opb   <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_part  <= '0;
        end else if (r_state == S_RUN) begin
            r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
            r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
            r_carry <= w_fa_c;
            r_cnt   <= r_cnt + CW'(1);
            r_part  <= w_part_full[WIDTH-1:1];
            if (w_last) begin
                // r_carry here is the carry entering the MSB step.
                r_sum  <= w_part_full;
                r_cout <= w_fa_c;
                r_ovf  <= r_carry ^ w_fa_c;
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule
